// File: rtl/edge_loader_pkg.sv
// Shared constants, FSM state encoding and start-range helper for edge_loader.
package edge_loader_pkg;

  localparam int DEFAULT_MAX_NODES   = 8;
  localparam int DEFAULT_INDEX_WIDTH = 4;
  localparam int DEFAULT_VALUE_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic n_in_range(input logic [31:0] n, input logic [31:0] max_n);
    return (n != '0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/edge_loader_if.sv
// Host stream plus edge-store write bus of edge_loader; slave is the loader side.
interface edge_loader_if
  import edge_loader_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
);
  logic                   start;
  logic [INDEX_WIDTH-1:0] num_nodes;
  logic                   in_valid;
  logic [VALUE_WIDTH-1:0] in_data;
  logic                   in_ready;
  logic [INDEX_WIDTH-1:0] from_node;
  logic [INDEX_WIDTH-1:0] to_node;
  logic                   write_enable;
  logic [VALUE_WIDTH-1:0] write_data;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output start, num_nodes, in_valid, in_data,
    input  in_ready, from_node, to_node, write_enable, write_data, busy, done, error
  );

  modport slave (
    input  start, num_nodes, in_valid, in_data,
    output in_ready, from_node, to_node, write_enable, write_data, busy, done, error
  );
endinterface

// File: rtl/edge_index_counter.sv
// Row-major (row, col) walker over an N x N matrix; last flags the final cell.
module edge_index_counter #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   step,
  input  logic [INDEX_WIDTH-1:0] n,
  output logic [INDEX_WIDTH-1:0] row,
  output logic [INDEX_WIDTH-1:0] col,
  output logic                   last
);
  localparam logic [INDEX_WIDTH-1:0] ONE = INDEX_WIDTH'(1);

  logic [INDEX_WIDTH-1:0] row_q, col_q;
  logic [INDEX_WIDTH-1:0] n_m1;

  assign n_m1 = n - ONE;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step) begin
      if (col_q == n_m1) begin
        col_q <= '0;
        row_q <= row_q + ONE;
      end else begin
        col_q <= col_q + ONE;
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == n_m1) && (col_q == n_m1);
endmodule

// File: rtl/edge_loader.sv
// Streams an N x N row-major weight matrix into an edge store, one write per beat.
// Optional macro EDGE_LOADER_DIAG_ZERO_EN: diagonal weights are written as zero.
module edge_loader
  import edge_loader_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  edge_loader_if.slave  bus
);
  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic                   we_q, done_q, err_q;
  logic [INDEX_WIDTH-1:0] from_q, to_q;
  logic [VALUE_WIDTH-1:0] wd_q;

  logic                   n_ok, load_start, accept, last;
  logic [INDEX_WIDTH-1:0] row, col;
  logic [VALUE_WIDTH-1:0] beat_data;

  assign n_ok       = n_in_range(32'(bus.num_nodes), 32'(MAX_NODES));
  assign load_start = (state_q == ST_IDLE) && bus.start && n_ok;
  assign accept     = (state_q == ST_LOAD) && bus.in_valid;

  edge_index_counter #(.INDEX_WIDTH(INDEX_WIDTH)) u_index (
    .clock (clock),
    .reset (reset),
    .clear (load_start),
    .step  (accept),
    .n     (n_q),
    .row   (row),
    .col   (col),
    .last  (last)
  );

`ifdef EDGE_LOADER_DIAG_ZERO_EN
  assign beat_data = (row == col) ? '0 : bus.in_data;
`else
  assign beat_data = bus.in_data;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      from_q  <= '0;
      to_q    <= '0;
      wd_q    <= '0;
    end else begin
      we_q   <= accept;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        from_q <= row;
        to_q   <= col;
        wd_q   <= beat_data;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (n_ok) begin
              n_q     <= bus.num_nodes;
              state_q <= ST_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // done is raised with the last beat so it lands on the same cycle as its write
        ST_LOAD: begin
          if (accept && last) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == ST_LOAD);
  assign bus.busy         = (state_q == ST_LOAD);
  assign bus.from_node    = from_q;
  assign bus.to_node      = to_q;
  assign bus.write_enable = we_q;
  assign bus.write_data   = wd_q;
  assign bus.done         = done_q;
  assign bus.error        = err_q;
endmodule

// File: tb/tb_edge_loader.sv
// Randomized bench for edge_loader against a matrix-walk reference model.
module tb_edge_loader;
  localparam int MAXN = 8;
  localparam int IW   = 4;
  localparam int VW   = 16;
`ifdef EDGE_LOADER_DIAG_ZERO_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edge_loader_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) bus ();

  edge_loader #(.MAX_NODES(MAXN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a load is a walk k = 0 .. N*N-1 with row = k/N, col = k%N.
  int          mphase = 0;  // 0 idle, 1 loading, 2 done cycle
  int          mk = 0, mN = 0;
  bit          armed = 1'b0;
  bit          exp_we, exp_done, exp_err;
  int          exp_from, exp_to, exp_wd;
  logic [VW-1:0] beats [0:64];

  always @(posedge clk) begin
    exp_we = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    if (rst) begin
      mphase = 0; mk = 0; mN = 0;
      exp_from = 0; exp_to = 0; exp_wd = 0;
      armed = 1'b1;
    end else begin
      case (mphase)
        0: if (bus.start) begin
             if (bus.num_nodes >= 1 && bus.num_nodes <= MAXN) begin
               mN = bus.num_nodes; mk = 0; mphase = 1;
             end else exp_err = 1'b1;
           end
        1: if (bus.in_valid) begin
             exp_we   = 1'b1;
             exp_from = mk / mN;
             exp_to   = mk % mN;
             exp_wd   = (DIAG && exp_from == exp_to) ? 0 : int'(bus.in_data);
             mk++;
             if (mk == mN * mN) begin exp_done = 1'b1; mphase = 2; end
           end
        default: mphase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("write_enable", bus.write_enable, exp_we);
      chk("done",         bus.done,         exp_done);
      chk("error",        bus.error,        exp_err);
      chk("busy",         bus.busy,         mphase == 1);
      chk("in_ready",     bus.in_ready,     mphase == 1);
      chk("from_node",    bus.from_node,    exp_from);
      chk("to_node",      bus.to_node,      exp_to);
      chk("write_data",   bus.write_data,   exp_wd);
    end
  end

  // Capture of observed writes/pulses for the hand-computed scenario checks.
  typedef struct { int from; int to; int data; int cyc; bit done; } wr_t;
  wr_t cap [$];
  int  cyc = 0, errcnt = 0, busycnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1)
      cap.push_back('{int'(bus.from_node), int'(bus.to_node), int'(bus.write_data), cyc, bus.done});
    if (bus.error === 1'b1) errcnt++;
    if (bus.busy === 1'b1) busycnt++;
  end

  // Stream driver: 0 = valid held, 1 = toggling, 2 = random.
  int vmode = 0;
  bit tog = 1'b0;
  always @(negedge clk) begin
    case (vmode)
      0:       bus.in_valid = 1'b1;
      1:       bus.in_valid = tog;
      default: bus.in_valid = ($urandom_range(0, 1) == 1);
    endcase
    tog = ~tog;
    bus.in_data = beats[mk];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input int n);
    bus.start = 1'b1;
    bus.num_nodes = IW'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (mphase == 0) begin ok = 1'b1; break; end
      tick();
    end
    chk("load_completes_in_budget", ok, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] diag_exp [4];
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_nodes = '0;
    for (int i = 0; i <= 64; i++) beats[i] = VW'(i + 1);
    tick(); tick();
    chk("reset_write_enable", bus.write_enable, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_error", bus.error, 0);
    chk("reset_from_node", bus.from_node, 0);
    rst = 1'b0;
    tick();

    // N=3, stream 1..9, valid held
    cap.delete(); vmode = 0;
    do_start(3); wait_idle(50); tick();
    chk("n3_write_count", cap.size(), 9);
    chk("n3_first_data", cap[0].data, DIAG ? 0 : 1);
    chk("n3_second_data", cap[1].data, 2);
    chk("n3_last_addr", cap[8].from * 16 + cap[8].to, 32'h22);
    chk("n3_last_data", cap[8].data, DIAG ? 0 : 9);
    chk("n3_consecutive", cap[8].cyc - cap[0].cyc, 8);
    chk("n3_done_on_last", cap[8].done, 1);
    chk("n3_no_early_done", cap[7].done, 0);

    // N=2, toggling valid
    cap.delete(); vmode = 1;
    do_start(2); wait_idle(50); tick();
    chk("n2_toggle_count", cap.size(), 4);
    chk("n2_addr0", cap[0].from * 16 + cap[0].to, 32'h00);
    chk("n2_addr1", cap[1].from * 16 + cap[1].to, 32'h01);
    chk("n2_addr2", cap[2].from * 16 + cap[2].to, 32'h10);
    chk("n2_addr3", cap[3].from * 16 + cap[3].to, 32'h11);
    chk("n2_stall_gap", cap[1].cyc - cap[0].cyc, 2);
    chk("n2_span", cap[3].cyc - cap[0].cyc, 6);

    // Rejected starts
    cap.delete(); errcnt = 0; busycnt = 0; vmode = 0;
    do_start(0); tick(); tick();
    do_start(MAXN + 1); tick(); tick();
    chk("reject_error_pulses", errcnt, 2);
    chk("reject_busy_cycles", busycnt, 0);
    chk("reject_writes", cap.size(), 0);

    // Reset mid-load, then fresh load
    cap.delete(); vmode = 0;
    do_start(3);
    for (int c = 0; c < 20; c++) begin
      if (mk >= 4) break;
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_write_enable", bus.write_enable, 0);
    chk("abort_busy", bus.busy, 0);
    tick();
    chk("abort_writes_before_reset", cap.size(), 4);
    cap.delete();
    for (int i = 0; i <= 64; i++) beats[i] = VW'(i + 20);
    do_start(2); wait_idle(50); tick();
    chk("restart_count", cap.size(), 4);
    chk("restart_addr0", cap[0].from * 16 + cap[0].to, 32'h00);
    chk("restart_data0", cap[0].data, DIAG ? 0 : 20);

    // Diagonal handling, N=2 stream 5,6,7,8
    cap.delete();
    for (int i = 0; i < 4; i++) beats[i] = VW'(i + 5);
    if (DIAG) diag_exp = '{16'd0, 16'd6, 16'd7, 16'd0};
    else      diag_exp = '{16'd5, 16'd6, 16'd7, 16'd8};
    do_start(2); wait_idle(50); tick();
    chk("diag_count", cap.size(), 4);
    for (int i = 0; i < 4; i++) chk("diag_data", cap[i].data, diag_exp[i]);

    // Start mid-load ignored
    cap.delete();
    for (int i = 0; i <= 64; i++) beats[i] = VW'(i + 1);
    do_start(3); tick(); tick();
    bus.start = 1'b1; bus.num_nodes = IW'(5); tick(); bus.start = 1'b0;
    wait_idle(50); tick();
    chk("midstart_count", cap.size(), 9);
    chk("midstart_last_addr", cap[8].from * 16 + cap[8].to, 32'h22);

    // Randomized loads with random stalls, stray starts and occasional resets
    for (int it = 0; it < 30; it++) begin
      bit done_ok = 1'b0;
      vmode = $urandom_range(0, 2);
      for (int i = 0; i <= 64; i++) beats[i] = VW'($urandom);
      do_start($urandom_range(0, 10));
      for (int c = 0; c < 400; c++) begin
        if (mphase == 0) begin done_ok = 1'b1; break; end
        bus.start = ($urandom_range(0, 15) == 0);
        bus.num_nodes = IW'($urandom);
        rst = ($urandom_range(0, 149) == 0);
        tick();
      end
      bus.start = 1'b0; rst = 1'b0;
      chk("random_load_terminates", done_ok, 1'b1);
      tick();
    end

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
